// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: owns the read/write pointers of an external
// dual-port RAM, gates its enables against full/empty and reports occupancy.
module sync_fifo_ctrl #(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic                       wenc,
  output logic [$clog2(DEPTH)-1:0]   waddr,
  output logic                       renc,
  output logic [$clog2(DEPTH)-1:0]   raddr,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);

  // MSB of each pointer is the wrap bit; only the low AW bits address the RAM.
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  // NOTE: flags decode the registered count only, so a request can never
  // combinationally influence its own gating (no wr_en -> full -> wenc loop).
  always_comb begin
    full         = (count == FULL_CNT);
    empty        = (count == '0);
    almost_full  = (count >= AF_CNT);
    almost_empty = (count <= AE_CNT);
  end

  always_comb begin
    wenc  = wr_en & ~full  & ~clr;
    renc  = rd_en & ~empty & ~clr;
    waddr = wptr[AW-1:0];
    raddr = rptr[AW-1:0];
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wenc) wptr <= wptr + ONE;
      if (renc) rptr <= rptr + ONE;

      case ({wenc, renc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase

      // RAM rdata is registered, so the popped word appears one cycle after renc.
      rd_valid <= renc;

      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock FIFO controller that sequences one `dual_port_RAM` instance (both RAM clocks tied to `clk`) as a synchronous FIFO. It owns the write and read pointers, gates RAM enables against full/empty, and produces occupancy count, threshold flags, sticky error flags and a read-data-valid strobe aligned to the RAM's registered `rdata`. The datapath (`wdata`/`rdata`) connects directly to the RAM and does not pass through this block.

## Interface
- `DEPTH`, 16: FIFO depth in words. Must be a power of two, ≥ 4. Must match the RAM `DEPTH`.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when `count` ≥ AF_LEVEL.
- `AE_LEVEL`, 2: `almost_empty` asserts when `count` ≤ AE_LEVEL.
- AW = $clog2(DEPTH) is a derived localparam.

Ports:
- `clk` in 1: single clock for the controller and both RAM ports.
- `rst` in 1: asynchronous, active-high reset.
- `clr` in 1: synchronous flush.
- `wr_en` in 1: write request from the producer.
- `rd_en` in 1: read request from the consumer.
- `wenc` out 1: RAM write enable.
- `waddr` out AW: RAM write address.
- `renc` out 1: RAM read enable.
- `raddr` out AW: RAM read address.
- `rd_valid` out 1: RAM `rdata` holds a popped word this cycle.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: count ≥ AF_LEVEL.
- `almost_empty` out 1: count ≤ AE_LEVEL.
- `count` out AW+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky flag. Set when a write is attempted while full.
- `underflow` out 1: sticky flag. Set when a read is attempted while empty.

## Operation
- State registers:
  - `wptr`, `rptr`: AW+1 bits each. The MSB is the wrap bit.
  - `count`: AW+1 bits.
  - `rd_valid`.
  - `overflow`, `underflow`.
- Write gating:
  - `wenc = wr_en & ~full & ~clr`.
  - `waddr = wptr[AW-1:0]`.
- Read gating:
  - `renc = rd_en & ~empty & ~clr`.
  - `raddr = rptr[AW-1:0]`.
- Pointer update: on each accepted write (`wenc`), `wptr` increments by 1. On each accepted read (`renc`), `rptr` increments by 1. Both increment modulo 2^(AW+1).
- Address wrap: after address DEPTH-1 the next address is 0, and the wrap bit toggles.
- Count update:
  - Write only: count +1.
  - Read only: count −1.
  - Both or neither: count unchanged.
- Count invariant: `count == wptr − rptr` (mod 2^(AW+1)) at all times.
- Flags: `full`, `empty`, `almost_full` and `almost_empty` are combinational decodes of the registered `count` only. They never depend on `wr_en` or `rd_en` in the same cycle.
- Read on full: a simultaneous `wr_en` and `rd_en` while full accepts the read and rejects the write. Count drops to DEPTH−1.
- Write on empty: a simultaneous `wr_en` and `rd_en` while empty accepts the write and rejects the read. Count rises to 1.
- Error flags:
  - `overflow` is set on any cycle with `wr_en & full & ~clr`.
  - `underflow` is set on any cycle with `rd_en & empty & ~clr`.
  - Both hold until `clr` or `rst`.
  - Rejected requests do not move pointers.
- `clr` (synchronous flush):
  - Next cycle: pointers = 0, count = 0, `rd_valid` = 0, `overflow` = 0, `underflow` = 0.
  - Same cycle: `wenc` and `renc` are forced to 0.
  - RAM contents are not touched.
- `rst` (asynchronous) forces the same register values as `clr`, immediately. `rst` mid-operation abandons any in-flight read: `rd_valid` clears, and the word is lost.

## Timing
- Reset values:
  - `wptr` = 0, `rptr` = 0, `count` = 0.
  - `rd_valid` = 0, `overflow` = 0, `underflow` = 0.
  - Therefore `empty` = 1, `full` = 0, `almost_empty` = 1, `almost_full` = 0.
  - `wenc` = 0, `renc` = 0, `waddr` = 0, `raddr` = 0.
- Write: a word presented with `wr_en` in cycle N is written at the edge ending N. `count` and flags reflect it in cycle N+1.
- Read latency: `renc` in cycle N → RAM `rdata` valid in cycle N+1. `rd_valid` = 1 in N+1 (this is `renc` registered).
- Back-to-back operation: one accepted read per cycle sustains a continuous `rd_valid` stream.
- Write-to-read latency: a word written in cycle N is readable (`empty` = 0) in N+1. A read in N+1 returns it in N+2.
- Same-address read/write: the RAM returns the old contents. This cannot occur for a live entry, because gating prevents reading an unwritten slot.

## Test plan
- Reset with DEPTH=16 → `empty`=1, `almost_empty`=1, `count`=0, all enables 0. Then 16 consecutive writes of 0x00..0x0F:
  - `count` = 16, `full` = 1.
  - `almost_full` rises when count reaches 14.
  - `waddr` sequence is 0..15.
- From full:
  - A 17th write → `wenc` = 0, `overflow` = 1, count stays 16.
  - Then 16 reads → `rd_valid` one cycle after each `renc`, RAM data 0x00..0x0F in order. Ends with `empty` = 1.
  - A further read → `underflow` = 1.
- Wrap: write 10, read 10, then write 10 → `waddr` runs 10..15 then 0..3. Wrap bit toggles, count = 10, no flag errors.
- Simultaneous `wr_en` + `rd_en` at count = 0, 5 and 16 → count becomes 1, 5 and 15 respectively. Only the legal side is enabled.
- `clr` asserted at count = 7 with `overflow` = 1 and `wr_en` = `rd_en` = 1:
  - `wenc` = `renc` = 0 in that cycle.
  - Next cycle: count = 0, `empty` = 1, `overflow` = 0.
- Async `rst` pulse mid-cycle, during a read in flight → all outputs at reset values immediately, without waiting for a clock edge. `rd_valid` does not assert afterward.
